// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: writer fills a free bank, reader takes the newest complete frame.
// Define FRAME_STATS_EN to build saturating dropped/captured frame counters.
module frame_bank_scheduler #(
  parameter int BANK_WORDS = 76800,
  parameter int LADDR_W    = 17,
  parameter int PADDR_W    = 18
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               cap_enable,
  input  logic               snapshot_req,
  input  logic               wr_frame_start,
  input  logic               wr_frame_end,
  input  logic [LADDR_W-1:0] wr_addr_in,
  input  logic               wr_we_in,
  input  logic [15:0]        wr_data_in,
  output logic [PADDR_W-1:0] wr_addr_out,
  output logic               wr_we_out,
  output logic [15:0]        wr_data_out,
  input  logic               rd_frame_start,
  input  logic [LADDR_W-1:0] rd_addr_in,
  output logic [PADDR_W-1:0] rd_addr_out,
  output logic [1:0]         wr_bank,
  output logic [1:0]         rd_bank,
  output logic               frozen,
  output logic               new_frame,
  output logic [15:0]        dropped_cnt,
  output logic [15:0]        captured_cnt
);
  localparam logic [PADDR_W-1:0] BASE_1    = PADDR_W'(BANK_WORDS);
  localparam logic [PADDR_W-1:0] BASE_2    = PADDR_W'(2 * BANK_WORDS);
  localparam logic [LADDR_W-1:0] LAST_ADDR = LADDR_W'(BANK_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITING, ST_FROZEN} wr_state_t;

  wr_state_t          r_state;
  logic [1:0]         r_wr_bank;
  logic [1:0]         r_rd_bank;
  logic [1:0]         r_spare_bank;
  logic               r_ready_valid;
  logic               r_snapshot_armed;
  logic               r_frozen;
  logic               r_new_frame;
  logic               r_wr_we;
  logic [PADDR_W-1:0] r_wr_addr;
  logic [15:0]        r_wr_data;
  logic [PADDR_W-1:0] r_rd_addr;

  logic               w_commit;
  logic               w_rd_take;
  logic [PADDR_W-1:0] w_wr_base;
  logic [PADDR_W-1:0] w_rd_base;
  logic [LADDR_W-1:0] w_rd_clamped;

  function automatic logic [PADDR_W-1:0] bank_base(input logic [1:0] bank);
    case (bank)
      2'd1:    bank_base = BASE_1;
      2'd2:    bank_base = BASE_2;
      default: bank_base = '0;
    endcase
  endfunction

  assign w_commit     = (r_state == ST_WRITING) && wr_frame_end;
  assign w_rd_take    = rd_frame_start && r_ready_valid;
  assign w_wr_base    = bank_base(r_wr_bank);
  assign w_rd_base    = bank_base(r_rd_bank);
  assign w_rd_clamped = (rd_addr_in > LAST_ADDR) ? LAST_ADDR : rd_addr_in;

  // Writer FSM; a pending snapshot is honoured only at a clean frame commit.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_snapshot_armed <= 1'b0;
      r_frozen         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (snapshot_req) r_snapshot_armed <= 1'b1;
          if (wr_frame_start && cap_enable) r_state <= ST_WRITING;
        end
        ST_WRITING: begin
          if (snapshot_req) r_snapshot_armed <= 1'b1;
          if (wr_frame_end) begin
            if (r_snapshot_armed) begin
              r_state          <= ST_FROZEN;
              r_frozen         <= 1'b1;
              r_snapshot_armed <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (wr_frame_start && !cap_enable) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FROZEN: begin
          if (snapshot_req) begin
            r_state  <= ST_IDLE;
            r_frozen <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bank rotation; a same-cycle commit hands the just-finished frame straight to the reader.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_wr_bank     <= 2'd0;
      r_rd_bank     <= 2'd2;
      r_spare_bank  <= 2'd1;
      r_ready_valid <= 1'b0;
      r_new_frame   <= 1'b0;
    end else begin
      r_new_frame <= 1'b0;
      if (w_commit && rd_frame_start) begin
        r_rd_bank     <= r_wr_bank;
        r_wr_bank     <= r_spare_bank;
        r_spare_bank  <= r_rd_bank;
        r_ready_valid <= 1'b0;
        r_new_frame   <= 1'b1;
      end else if (w_commit) begin
        r_wr_bank     <= r_spare_bank;
        r_spare_bank  <= r_wr_bank;
        r_ready_valid <= 1'b1;
      end else if (w_rd_take) begin
        r_rd_bank     <= r_spare_bank;
        r_spare_bank  <= r_rd_bank;
        r_ready_valid <= 1'b0;
        r_new_frame   <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_wr_we   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
    end else begin
      r_wr_we   <= wr_we_in && (r_state == ST_WRITING) && (wr_addr_in <= LAST_ADDR);
      r_wr_addr <= w_wr_base + PADDR_W'(wr_addr_in);
      r_wr_data <= wr_data_in;
      r_rd_addr <= w_rd_base + PADDR_W'(w_rd_clamped);
    end
  end

`ifdef FRAME_STATS_EN
  logic [15:0] r_dropped_cnt;
  logic [15:0] r_captured_cnt;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_dropped_cnt  <= '0;
      r_captured_cnt <= '0;
    end else if (w_commit) begin
      if (r_ready_valid && (r_dropped_cnt != 16'hFFFF)) r_dropped_cnt <= r_dropped_cnt + 16'd1;
      if (r_captured_cnt != 16'hFFFF) r_captured_cnt <= r_captured_cnt + 16'd1;
    end
  end

  assign dropped_cnt  = r_dropped_cnt;
  assign captured_cnt = r_captured_cnt;
`else
  assign dropped_cnt  = '0;
  assign captured_cnt = '0;
`endif

  assign wr_addr_out = r_wr_addr;
  assign wr_we_out   = r_wr_we;
  assign wr_data_out = r_wr_data;
  assign rd_addr_out = r_rd_addr;
  assign wr_bank     = r_wr_bank;
  assign rd_bank     = r_rd_bank;
  assign frozen      = r_frozen;
  assign new_frame   = r_new_frame;
endmodule
